cordic_csqrt_sequencer: RTL and testbench

- Parametrised, handshaked successor to the fixed 16-bit complex-square-root mux controller.
- Sequences one external CORDIC vectoring core (CV) and one external CORDIC rotation core (CR) through the four-pass complex sqrt algorithm:
  - CV1: angle phi
  - CR1: cos/sin of phi
  - CV2: psi = half-angle via the 2R-1 path
  - CR2: root
- Adds input/output valid-ready handshakes, channel-tag passthrough, shift saturation and a per-pass timeout with error flag.
- Sits between the sample source and the result consumer; the CORDIC cores are instantiated alongside it.

---
 rtl/cordic_csqrt_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_cordic_csqrt_sequencer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_csqrt_sequencer.sv
// cordic_csqrt_sequencer
// Runs one external CORDIC vectoring core (CV) and one external CORDIC
// rotation core (CR) through the four passes of the complex square root:
// CV1 (angle phi), CR1 (cos/sin of phi), CV2 (half angle psi from 2R-1),
// CR2 (root). Wraps the passes in valid/ready handshakes, passes a channel
// tag through, saturates the final scaling shift and aborts any pass whose
// core fails to answer within TIMEOUT cycles.
module cordic_csqrt_sequencer #(
    parameter int                DATA_W  = 16,
    parameter int                ANG_W   = 32,
    parameter int                SHIFT_W = 4,
    parameter int                TAG_W   = 3,
    parameter logic [DATA_W-1:0] K_INV   = 16'h4DB9,
    parameter logic [DATA_W-1:0] ONE     = 16'h7FFF,
    parameter int                TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_x,
    input  logic [DATA_W-1:0]  in_y,
    input  logic [TAG_W-1:0]   in_tag,

    output logic               cv_start,
    output logic               cv_sel,
    output logic [DATA_W-1:0]  cv_xin,
    output logic [DATA_W-1:0]  cv_yin,
    output logic [DATA_W-1:0]  cv_yn,
    input  logic               cv_done,
    input  logic [ANG_W-1:0]   cv_microt,
    input  logic [DATA_W-1:0]  cv_2rm1,
    input  logic [SHIFT_W-1:0] cv_l,
    input  logic [1:0]         cv_quad,

    output logic               cr_start,
    output logic [DATA_W-1:0]  cr_xin,
    output logic [DATA_W-1:0]  cr_yin,
    output logic [ANG_W-1:0]   cr_microt,
    input  logic               cr_done,
    input  logic [DATA_W-1:0]  cr_cos,
    input  logic [DATA_W-1:0]  cr_sin,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_re,
    output logic [DATA_W-1:0]  out_im,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    // The wait counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Wide enough that a shift by the largest l never loses bits before the
    // saturation compare.
    localparam int EXT_W = DATA_W + (1 << SHIFT_W);

    localparam logic [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] EXT_MAX =
        {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] EXT_MIN =
        {{(EXT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [3:0] {
        IDLE,
        CV1_GO,
        CV1_WAIT,
        CR1_GO,
        CR1_WAIT,
        CV2_GO,
        CV2_WAIT,
        CR2_GO,
        CR2_WAIT,
        OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0]  x_q;
    logic [DATA_W-1:0]  y_q;
    logic [TAG_W-1:0]   tag_q;
    logic [ANG_W-1:0]   phi_q;
    logic [ANG_W-1:0]   psi_q;
    logic [DATA_W-1:0]  two_rm1_q;
    logic [SHIFT_W-1:0] l_q;
    logic [1:0]         quad_q;
    logic [DATA_W-1:0]  c1_q;
    logic [DATA_W-1:0]  s1_q;
    logic [DATA_W-1:0]  res_re_q;
    logic [DATA_W-1:0]  res_im_q;
    logic               err_q;
    logic [CNT_W-1:0]   wait_cnt;

    logic               timed_out;
    logic               wait_state;
    logic               wait_done;
    logic               wait_abort;
    logic [DATA_W-1:0]  map_re;
    logic [DATA_W-1:0]  map_im;

    // Arithmetic left shift by sh, clamped to the signed DATA_W range.
    function automatic logic [DATA_W-1:0] sat_shl(input logic [DATA_W-1:0]  v,
                                                  input logic [SHIFT_W-1:0] sh);
        logic signed [EXT_W-1:0] wide;
        wide = {{(EXT_W-DATA_W){v[DATA_W-1]}}, v};
        wide = wide <<< sh;
        if (wide > EXT_MAX) begin
            sat_shl = D_MAX;
        end else if (wide < EXT_MIN) begin
            sat_shl = D_MIN;
        end else begin
            sat_shl = wide[DATA_W-1:0];
        end
    endfunction

    // Two's complement negate; the most negative value clamps to max positive.
    function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] v);
        if (v == D_MIN) begin
            sat_neg = D_MAX;
        end else begin
            sat_neg = ~v + 1'b1;
        end
    endfunction

    assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Which wait state we are in, and whether its core answered this cycle.
    always_comb begin
        wait_state = 1'b0;
        wait_done  = 1'b0;
        case (state)
            CV1_WAIT, CV2_WAIT: begin
                wait_state = 1'b1;
                wait_done  = cv_done;
            end
            CR1_WAIT, CR2_WAIT: begin
                wait_state = 1'b1;
                wait_done  = cr_done;
            end
            default: begin
                wait_state = 1'b0;
                wait_done  = 1'b0;
            end
        endcase
        wait_abort = wait_state && !wait_done && timed_out;
    end

    // Map the final rotation back to the input quadrant before scaling.
    always_comb begin
        map_re = cr_cos;
        map_im = cr_sin;
        case (quad_q)
            2'b10: begin
                map_re = cr_sin;
                map_im = cr_cos;
            end
            2'b11: begin
                map_re = cr_sin;
                map_im = sat_neg(cr_cos);
            end
            default: begin
                map_re = cr_cos;
                map_im = cr_sin;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and all block outputs, derived from the current state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        cv_start  = 1'b0;
        cv_sel    = 1'b0;
        cv_xin    = '0;
        cv_yin    = '0;
        cv_yn     = '0;
        cr_start  = 1'b0;
        cr_xin    = '0;
        cr_yin    = '0;
        cr_microt = '0;
        out_valid = 1'b0;
        out_re    = '0;
        out_im    = '0;
        out_tag   = '0;
        out_err   = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = CV1_GO;
                end
            end
            CV1_GO: begin
                cv_start  = 1'b1;
                cv_xin    = x_q;
                cv_yin    = y_q;
                state_nxt = CV1_WAIT;
            end
            CV1_WAIT: begin
                if (cv_done) begin
                    state_nxt = CR1_GO;
                end else if (timed_out) begin
                    state_nxt = OUT;
                end
            end
            CR1_GO: begin
                cr_start  = 1'b1;
                cr_xin    = ONE;
                cr_microt = phi_q;
                state_nxt = CR1_WAIT;
            end
            CR1_WAIT: begin
                if (cr_done) begin
                    state_nxt = CV2_GO;
                end else if (timed_out) begin
                    state_nxt = OUT;
                end
            end
            CV2_GO: begin
                cv_start  = 1'b1;
                cv_sel    = 1'b1;
                cv_xin    = K_INV;
                cv_yn     = two_rm1_q;
                state_nxt = CV2_WAIT;
            end
            CV2_WAIT: begin
                if (cv_done) begin
                    state_nxt = CR2_GO;
                end else if (timed_out) begin
                    state_nxt = OUT;
                end
            end
            CR2_GO: begin
                cr_start  = 1'b1;
                cr_xin    = two_rm1_q[DATA_W-1] ? s1_q : c1_q;
                cr_microt = psi_q;
                state_nxt = CR2_WAIT;
            end
            CR2_WAIT: begin
                if (cr_done) begin
                    state_nxt = OUT;
                end else if (timed_out) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                out_re    = res_re_q;
                out_im    = res_im_q;
                out_tag   = tag_q;
                out_err   = err_q;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand and result capture, plus the per-pass wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            tag_q     <= '0;
            phi_q     <= '0;
            psi_q     <= '0;
            two_rm1_q <= '0;
            l_q       <= '0;
            quad_q    <= '0;
            c1_q      <= '0;
            s1_q      <= '0;
            res_re_q  <= '0;
            res_im_q  <= '0;
            err_q     <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q      <= in_x;
                        y_q      <= in_y;
                        tag_q    <= in_tag;
                        err_q    <= 1'b0;
                        res_re_q <= '0;
                        res_im_q <= '0;
                    end
                end
                CV1_GO, CR1_GO, CV2_GO, CR2_GO: begin
                    wait_cnt <= '0;
                end
                CV1_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (cv_done) begin
                        phi_q     <= cv_microt;
                        two_rm1_q <= cv_2rm1;
                        l_q       <= cv_l;
                        quad_q    <= cv_quad;
                    end
                end
                CR1_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (cr_done) begin
                        c1_q <= cr_cos;
                        s1_q <= cr_sin;
                    end
                end
                CV2_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (cv_done) begin
                        psi_q <= cv_microt;
                    end
                end
                CR2_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (cr_done) begin
                        res_re_q <= sat_shl(map_re, l_q);
                        res_im_q <= sat_shl(map_im, l_q);
                    end
                end
                default: begin
                end
            endcase

            if (wait_abort) begin
                res_re_q <= '0;
                res_im_q <= '0;
                err_q    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_csqrt_sequencer.sv
// Directed testbench for cordic_csqrt_sequencer with behavioural CV/CR stubs.
module tb_cordic_csqrt_sequencer;

    localparam int DATA_W  = 16;
    localparam int ANG_W   = 32;
    localparam int SHIFT_W = 4;
    localparam int TAG_W   = 3;
    localparam int TIMEOUT = 20;
    localparam int LAT     = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_x;
    logic [DATA_W-1:0]  in_y;
    logic [TAG_W-1:0]   in_tag;
    logic               cv_start;
    logic               cv_sel;
    logic [DATA_W-1:0]  cv_xin;
    logic [DATA_W-1:0]  cv_yin;
    logic [DATA_W-1:0]  cv_yn;
    logic               cv_done;
    logic [ANG_W-1:0]   cv_microt;
    logic [DATA_W-1:0]  cv_2rm1;
    logic [SHIFT_W-1:0] cv_l;
    logic [1:0]         cv_quad;
    logic               cr_start;
    logic [DATA_W-1:0]  cr_xin;
    logic [DATA_W-1:0]  cr_yin;
    logic [ANG_W-1:0]   cr_microt;
    logic               cr_done;
    logic [DATA_W-1:0]  cr_cos;
    logic [DATA_W-1:0]  cr_sin;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_re;
    logic [DATA_W-1:0]  out_im;
    logic [TAG_W-1:0]   out_tag;
    logic               out_err;

    int n_checks = 0;
    int n_errors = 0;

    // Stub core configuration for the current transaction
    logic [ANG_W-1:0]   st_phi, st_psi;
    logic [DATA_W-1:0]  st_2rm1, st_c1, st_s1, st_c2, st_s2;
    logic [SHIFT_W-1:0] st_l;
    logic [1:0]         st_quad;
    bit                 cv_en = 1'b1;
    bit                 cr_en = 1'b1;

    // Start log for the current transaction
    int                 cv_cnt, cr_cnt, both_cnt, start_idx, cr_pass;
    logic [3:0]         order_log;
    logic [DATA_W-1:0]  log_cv1_xin, log_cv1_yin, log_cv1_yn, log_cv2_xin, log_cv2_yn;
    logic               log_cv1_sel, log_cv2_sel;
    logic [DATA_W-1:0]  log_cr1_xin, log_cr2_xin, log_cr1_yin, log_cr2_yin;
    logic [ANG_W-1:0]   log_cr1_mt, log_cr2_mt;

    cordic_csqrt_sequencer #(
        .DATA_W (DATA_W),
        .ANG_W  (ANG_W),
        .SHIFT_W(SHIFT_W),
        .TAG_W  (TAG_W),
        .K_INV  (16'h4DB9),
        .ONE    (16'h7FFF),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_tag   (in_tag),
        .cv_start (cv_start),
        .cv_sel   (cv_sel),
        .cv_xin   (cv_xin),
        .cv_yin   (cv_yin),
        .cv_yn    (cv_yn),
        .cv_done  (cv_done),
        .cv_microt(cv_microt),
        .cv_2rm1  (cv_2rm1),
        .cv_l     (cv_l),
        .cv_quad  (cv_quad),
        .cr_start (cr_start),
        .cr_xin   (cr_xin),
        .cr_yin   (cr_yin),
        .cr_microt(cr_microt),
        .cr_done  (cr_done),
        .cr_cos   (cr_cos),
        .cr_sin   (cr_sin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_tag  (out_tag),
        .out_err  (out_err)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural CV and CR cores: done pulses LAT cycles after start,
    // results only valid on the done cycle, garbage otherwise.
    initial begin
        automatic bit cv_pend = 1'b0;
        automatic bit cr_pend = 1'b0;
        automatic int cv_tmr  = 0;
        automatic int cr_tmr  = 0;
        automatic bit cv_p2   = 1'b0;
        automatic int cr_p    = 0;
        cv_done = 1'b0; cr_done = 1'b0;
        cv_microt = '1; cv_2rm1 = 16'h5555; cv_l = 4'hF; cv_quad = 2'b01;
        cr_cos = 16'hA5A5; cr_sin = 16'h5A5A;
        forever begin
            @(negedge clk);
            cv_done = 1'b0; cr_done = 1'b0;
            cv_microt = '1; cv_2rm1 = 16'h5555; cv_l = 4'hF; cv_quad = 2'b01;
            cr_cos = 16'hA5A5; cr_sin = 16'h5A5A;
            if (cv_pend) begin
                cv_tmr--;
                if (cv_tmr == 0) begin
                    cv_pend = 1'b0;
                    if (cv_en) begin
                        cv_done = 1'b1;
                        if (cv_p2) begin
                            cv_microt = st_psi;
                            cv_2rm1   = ~st_2rm1;
                            cv_l      = ~st_l;
                            cv_quad   = ~st_quad;
                        end else begin
                            cv_microt = st_phi;
                            cv_2rm1   = st_2rm1;
                            cv_l      = st_l;
                            cv_quad   = st_quad;
                        end
                    end
                end
            end
            if (cr_pend) begin
                cr_tmr--;
                if (cr_tmr == 0) begin
                    cr_pend = 1'b0;
                    if (cr_en) begin
                        cr_done = 1'b1;
                        cr_cos  = (cr_p == 0) ? st_c1 : st_c2;
                        cr_sin  = (cr_p == 0) ? st_s1 : st_s2;
                    end
                end
            end
            if (cv_start) begin
                cv_pend = 1'b1; cv_tmr = LAT; cv_p2 = cv_sel;
                if (cv_sel) begin
                    log_cv2_xin = cv_xin; log_cv2_yn = cv_yn; log_cv2_sel = cv_sel;
                end else begin
                    log_cv1_xin = cv_xin; log_cv1_yin = cv_yin; log_cv1_yn = cv_yn;
                    log_cv1_sel = cv_sel;
                end
                if (start_idx < 4) order_log[start_idx] = 1'b0;
                start_idx++;
                cv_cnt++;
            end
            if (cr_start) begin
                cr_pend = 1'b1; cr_tmr = LAT; cr_p = cr_pass;
                if (cr_pass == 0) begin
                    log_cr1_xin = cr_xin; log_cr1_yin = cr_yin; log_cr1_mt = cr_microt;
                end else begin
                    log_cr2_xin = cr_xin; log_cr2_yin = cr_yin; log_cr2_mt = cr_microt;
                end
                if (start_idx < 4) order_log[start_idx] = 1'b1;
                start_idx++;
                cr_pass++;
                cr_cnt++;
            end
            if (cv_start && cr_start) both_cnt++;
        end
    end

    task automatic configStub(input logic [ANG_W-1:0] phi, input logic [DATA_W-1:0] r2m1,
                              input logic [SHIFT_W-1:0] l, input logic [1:0] quad,
                              input logic [ANG_W-1:0] psi,
                              input logic [DATA_W-1:0] c1, input logic [DATA_W-1:0] s1,
                              input logic [DATA_W-1:0] c2, input logic [DATA_W-1:0] s2);
        st_phi = phi; st_2rm1 = r2m1; st_l = l; st_quad = quad; st_psi = psi;
        st_c1 = c1; st_s1 = s1; st_c2 = c2; st_s2 = s2;
        cv_cnt = 0; cr_cnt = 0; start_idx = 0; cr_pass = 0; order_log = 4'hF;
        log_cv1_xin = 'x; log_cv1_yin = 'x; log_cv1_yn = 'x; log_cv2_xin = 'x; log_cv2_yn = 'x;
        log_cv1_sel = 'x; log_cv2_sel = 'x; log_cr1_xin = 'x; log_cr2_xin = 'x;
        log_cr1_yin = 'x; log_cr2_yin = 'x; log_cr1_mt = 'x; log_cr2_mt = 'x;
    endtask

    // Present one request at a negedge and hold it for exactly one accept edge
    task automatic applyStimulus(input string pfx, input logic [DATA_W-1:0] x,
                                 input logic [DATA_W-1:0] y, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1; in_x = x; in_y = y; in_tag = tag;
        checkOutput({pfx, ".in_ready_before"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({pfx, ".in_ready_after"}, in_ready, 0);
    endtask

    task automatic waitResult(input string pfx);
        for (int i = 0; i < 300; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        checkOutput({pfx, ".out_valid"}, out_valid, 1);
    endtask

    task automatic checkResult(input string pfx, input logic [DATA_W-1:0] re,
                               input logic [DATA_W-1:0] im, input logic [TAG_W-1:0] tag,
                               input logic err);
        checkOutput({pfx, ".out_re"}, out_re, re);
        checkOutput({pfx, ".out_im"}, out_im, im);
        checkOutput({pfx, ".out_tag"}, out_tag, tag);
        checkOutput({pfx, ".out_err"}, out_err, err);
    endtask

    task automatic checkPasses(input string pfx, input logic [DATA_W-1:0] x,
                               input logic [DATA_W-1:0] y, input logic [DATA_W-1:0] r2m1,
                               input logic [ANG_W-1:0] phi, input logic [ANG_W-1:0] psi,
                               input logic [DATA_W-1:0] cr2x);
        checkOutput({pfx, ".cv_starts"}, cv_cnt, 2);
        checkOutput({pfx, ".cr_starts"}, cr_cnt, 2);
        checkOutput({pfx, ".order"}, order_log, 4'b1010);
        checkOutput({pfx, ".cv1_xin"}, log_cv1_xin, x);
        checkOutput({pfx, ".cv1_yin"}, log_cv1_yin, y);
        checkOutput({pfx, ".cv1_yn"}, log_cv1_yn, 0);
        checkOutput({pfx, ".cv1_sel"}, log_cv1_sel, 0);
        checkOutput({pfx, ".cv2_xin"}, log_cv2_xin, 16'h4DB9);
        checkOutput({pfx, ".cv2_yn"}, log_cv2_yn, r2m1);
        checkOutput({pfx, ".cv2_sel"}, log_cv2_sel, 1);
        checkOutput({pfx, ".cr1_xin"}, log_cr1_xin, 16'h7FFF);
        checkOutput({pfx, ".cr1_yin"}, log_cr1_yin, 0);
        checkOutput({pfx, ".cr1_microt"}, log_cr1_mt, phi);
        checkOutput({pfx, ".cr2_xin"}, log_cr2_xin, cr2x);
        checkOutput({pfx, ".cr2_yin"}, log_cr2_yin, 0);
        checkOutput({pfx, ".cr2_microt"}, log_cr2_mt, psi);
    endtask

    // Accept the held result and confirm the block goes idle
    task automatic releaseOut(input string pfx);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({pfx, ".valid_dropped"}, out_valid, 0);
        checkOutput({pfx, ".idle_ready"}, in_ready, 1);
    endtask

    initial begin
        int n;
        int viol;
        int late_done;
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_tag = '0; out_ready = 1'b0;
        both_cnt = 0;
        configStub(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset.in_ready", in_ready, 1);
        checkOutput("reset.out_valid", out_valid, 0);
        checkOutput("reset.out_err", out_err, 0);
        checkOutput("reset.cv_start", cv_start, 0);
        checkOutput("reset.cr_start", cr_start, 0);
        @(negedge clk);

        // Nominal quadrant 0, l=1, positive 2R-1
        configStub(32'h12345678, 16'h0100, 4'd1, 2'b00, 32'h0ABCDEF0,
                   16'h3000, 16'h2000, 16'h2000, 16'h1000);
        applyStimulus("nom", 16'h1000, 16'h0800, 3'd5);
        waitResult("nom");
        checkResult("nom", 16'h4000, 16'h2000, 3'd5, 1'b0);
        checkPasses("nom", 16'h1000, 16'h0800, 16'h0100, 32'h12345678, 32'h0ABCDEF0, 16'h3000);
        releaseOut("nom");

        // Quadrant 11, l=0, negative 2R-1 selects CR1 sin for CR2
        configStub(32'h00000F0F, 16'hFF00, 4'd0, 2'b11, 32'h80000001,
                   16'h3000, 16'h2000, 16'h1234, 16'h0100);
        applyStimulus("q11", 16'hF000, 16'hF800, 3'd2);
        waitResult("q11");
        checkResult("q11", 16'h0100, 16'hEDCC, 3'd2, 1'b0);
        checkPasses("q11", 16'hF000, 16'hF800, 16'hFF00, 32'h00000F0F, 32'h80000001, 16'h2000);
        releaseOut("q11");

        // Positive saturation on the shift
        configStub(32'h00001111, 16'h7FFF, 4'd1, 2'b00, 32'h00002222,
                   16'h1111, 16'h2222, 16'h6000, 16'h0800);
        applyStimulus("satp", 16'h0100, 16'h0200, 3'd7);
        waitResult("satp");
        checkResult("satp", 16'h7FFF, 16'h1000, 3'd7, 1'b0);
        releaseOut("satp");

        // Negating the most negative value clamps to max positive
        configStub(32'h00003333, 16'h8000, 4'd0, 2'b11, 32'h00004444,
                   16'h1111, 16'h2222, 16'h8000, 16'h0001);
        applyStimulus("negmin", 16'h8001, 16'hFFFF, 3'd0);
        waitResult("negmin");
        checkResult("negmin", 16'h0001, 16'h7FFF, 3'd0, 1'b0);
        checkPasses("negmin", 16'h8001, 16'hFFFF, 16'h8000, 32'h00003333, 32'h00004444, 16'h2222);
        releaseOut("negmin");

        // Quadrant 10 with negative saturation on the shift
        configStub(32'h00005555, 16'h0010, 4'd2, 2'b10, 32'h00006666,
                   16'h1111, 16'h2222, 16'h0100, 16'hC000);
        applyStimulus("q10", 16'hC000, 16'h0100, 3'd1);
        waitResult("q10");
        checkResult("q10", 16'h8000, 16'h0400, 3'd1, 1'b0);
        releaseOut("q10");

        // Backpressure: hold out_ready low while a second request waits
        configStub(32'h12345678, 16'h0100, 4'd1, 2'b00, 32'h0ABCDEF0,
                   16'h3000, 16'h2000, 16'h2000, 16'h1000);
        applyStimulus("bpA", 16'h1000, 16'h0800, 3'd4);
        waitResult("bpA");
        checkResult("bpA", 16'h4000, 16'h2000, 3'd4, 1'b0);
        configStub(32'h0000AAAA, 16'h0200, 4'd0, 2'b00, 32'h0000BBBB,
                   16'h0123, 16'h0456, 16'h0789, 16'h0ABC);
        in_valid = 1'b1; in_x = 16'h0321; in_y = 16'h0654; in_tag = 3'd6;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp.hold_valid", out_valid, 1);
            checkOutput("bp.hold_re", out_re, 16'h4000);
            checkOutput("bp.hold_im", out_im, 16'h2000);
            checkOutput("bp.hold_tag", out_tag, 3'd4);
            checkOutput("bp.hold_in_ready", in_ready, 0);
            checkOutput("bp.hold_no_cv_start", cv_start, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp.release_valid", out_valid, 0);
        checkOutput("bp.release_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp.accept_cv_start", cv_start, 1);
        checkOutput("bp.accept_in_ready", in_ready, 0);
        waitResult("bpB");
        checkResult("bpB", 16'h0789, 16'h0ABC, 3'd6, 1'b0);
        checkPasses("bpB", 16'h0321, 16'h0654, 16'h0200, 32'h0000AAAA, 32'h0000BBBB, 16'h0123);
        releaseOut("bpB");

        // Timeout: CR never answers
        configStub(32'h00000777, 16'h0100, 4'd1, 2'b00, 32'h00000888,
                   16'h3000, 16'h2000, 16'h2000, 16'h1000);
        cr_en = 1'b0;
        applyStimulus("to", 16'h0111, 16'h0222, 3'd3);
        for (int i = 0; i < 100; i++) begin
            if (cr_start) break;
            @(negedge clk);
        end
        checkOutput("to.cr_start_seen", cr_start, 1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        checkOutput("to.wait_cycles", n, TIMEOUT);
        waitResult("to");
        checkResult("to", 16'h0000, 16'h0000, 3'd3, 1'b1);
        releaseOut("to");
        cr_en = 1'b1;

        // Reset during CV2_WAIT; the late cv_done must be ignored
        configStub(32'h12345678, 16'h0100, 4'd1, 2'b00, 32'h0ABCDEF0,
                   16'h3000, 16'h2000, 16'h2000, 16'h1000);
        applyStimulus("rst", 16'h1000, 16'h0800, 3'd1);
        for (int i = 0; i < 100; i++) begin
            if (cv_start && cv_sel) break;
            @(negedge clk);
        end
        checkOutput("rst.cv2_seen", cv_start & cv_sel, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst.in_ready", in_ready, 1);
        checkOutput("rst.out_valid", out_valid, 0);
        checkOutput("rst.cv_start", cv_start, 0);
        checkOutput("rst.cr_start", cr_start, 0);
        viol = 0;
        late_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (cv_done) late_done++;
            if (!in_ready || out_valid || cv_start || cr_start) viol++;
        end
        checkOutput("rst.late_done_seen", late_done, 1);
        checkOutput("rst.idle_violations", viol, 0);

        // Recovery after the aborted operation
        configStub(32'h12345678, 16'h0100, 4'd1, 2'b00, 32'h0ABCDEF0,
                   16'h3000, 16'h2000, 16'h2000, 16'h1000);
        applyStimulus("rec", 16'h1000, 16'h0800, 3'd5);
        waitResult("rec");
        checkResult("rec", 16'h4000, 16'h2000, 3'd5, 1'b0);
        releaseOut("rec");

        checkOutput("global.simultaneous_starts", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
